// File: rtl/counter_load_sequencer.sv
// Load-interface master for a cascade of 4-bit up/down counter stages: freezes the
// chain, strobes each stage's nibble onto a shared data bus in turn, then releases it.
module counter_load_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [4*NIBBLES-1:0] value,
    input  logic                 dir_in,
    output logic [3:0]           data_out,
    output logic [NIBBLES-1:0]   write_out,
    output logic                 store_out,
    output logic                 updown_out,
    output logic                 busy,
    output logic                 done
);

    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_INDEX = IW'(NIBBLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FREEZE = 3'd1,
        SETUP  = 3'd2,
        STROBE = 3'd3,
        HOLD   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t                 state_r;
    logic [IW-1:0]          index_r;
    logic [4*NIBBLES-1:0]   value_r;

    function automatic logic [3:0] nibble_at(input logic [4*NIBBLES-1:0] v,
                                             input logic [IW-1:0]        idx);
        logic [4*NIBBLES-1:0] shifted;
        shifted = v >> {idx, 2'b00};
        return shifted[3:0];
    endfunction

    function automatic logic [NIBBLES-1:0] one_hot(input logic [IW-1:0] idx);
        return NIBBLES'(1) << idx;
    endfunction

    // Load sequencer FSM; every output is registered and updated together with the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            index_r    <= {IW{1'b0}};
            value_r    <= {(4*NIBBLES){1'b0}};
            data_out   <= 4'h0;
            write_out  <= {NIBBLES{1'b0}};
            store_out  <= 1'b0;
            updown_out <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && (state_r != IDLE) && (state_r != DONE)) begin
                // Stages already written keep their values; the chain is simply released.
                state_r   <= IDLE;
                write_out <= {NIBBLES{1'b0}};
                store_out <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state_r)
                    IDLE, DONE: begin
                        if (start && !abort) begin
                            state_r    <= FREEZE;
                            index_r    <= {IW{1'b0}};
                            value_r    <= value;
                            updown_out <= dir_in;
                            write_out  <= {NIBBLES{1'b0}};
                            store_out  <= 1'b1;
                            busy       <= 1'b1;
                        end else begin
                            state_r    <= IDLE;
                            updown_out <= dir_in;
                            write_out  <= {NIBBLES{1'b0}};
                            store_out  <= 1'b0;
                            busy       <= 1'b0;
                        end
                    end
                    FREEZE: begin
                        state_r   <= SETUP;
                        data_out  <= nibble_at(value_r, index_r);
                        write_out <= {NIBBLES{1'b0}};
                    end
                    SETUP: begin
                        state_r   <= STROBE;
                        write_out <= one_hot(index_r);
                    end
                    STROBE: begin
                        state_r   <= HOLD;
                        write_out <= {NIBBLES{1'b0}};
                    end
                    HOLD: begin
                        write_out <= {NIBBLES{1'b0}};
                        if (index_r == LAST_INDEX) begin
                            state_r   <= DONE;
                            store_out <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            // Next nibble goes on the bus as we re-enter SETUP.
                            state_r  <= SETUP;
                            index_r  <= index_r + IW'(1);
                            data_out <= nibble_at(value_r, index_r + IW'(1));
                        end
                    end
                    default: begin
                        state_r   <= IDLE;
                        write_out <= {NIBBLES{1'b0}};
                        store_out <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/counter_load_sequencer.md
Name: counter_load_sequencer

Overview:
- Master-side driver for the load interface of a cascade of 4-bit up/down counter stages: the writer for the counters' data/write/store/updown inputs.
- Takes a wide preset value plus a one-cycle start request.
- Freezes the cascade with store, then strobes each stage's write in turn with its nibble on a shared data bus, and releases the cascade.
- Sits between control logic (timer/prescaler setup) and the counter chain.

Parameters:
- NIBBLES, 4, number of cascaded 4-bit counter stages driven. Legal range 1..8.

Ports:
- clock, input, 1, rising-edge system clock.
- reset, input, 1, asynchronous, active-high.
- start, input, 1, one-cycle load request; sampled on a rising clock edge.
- abort, input, 1, cancels a load in progress.
- value, input, 4*NIBBLES, preset value; nibble i (value[4i+3:4i]) goes to stage i.
- dir_in, input, 1, requested count direction (1 = up, 0 = down).
- data_out, output, 4, shared nibble bus to every stage's data input.
- write_out, output, NIBBLES, one-hot write strobes, bit i to stage i.
- store_out, output, 1, freeze to all stages; high for the whole load.
- updown_out, output, 1, registered direction to all stages.
- busy, output, 1, load in progress.
- done, output, 1, one-cycle pulse when a load completes normally.

Behaviour:
- All outputs are registered. There is no combinational path from inputs to outputs.
- Reset (asynchronous, dominates everything):
  - state = IDLE.
  - data_out = 0, write_out = 0, store_out = 0, busy = 0, done = 0.
  - updown_out = 1; the index counter and captured value are cleared.
- States: IDLE, FREEZE, SETUP, STROBE, HOLD, DONE.
- IDLE / DONE:
  - start = 1 captures value into an internal register and captures dir_in into updown_out.
  - The next state is FREEZE, with index = 0.
  - Back-to-back start is legal in the DONE cycle.
- Direction capture:
  - When idle and start = 0, updown_out tracks dir_in with one cycle of latency.
  - updown_out holds constant from start acceptance until the return to IDLE/DONE.
- FREEZE (one cycle): store_out = 1, busy = 1, write_out = 0. Next state is SETUP.
- SETUP: data_out = captured nibble[index], write_out = 0 (data setup cycle). Next state is STROBE.
- STROBE: data_out unchanged, write_out[index] = 1, all other bits 0. Next state is HOLD.
- HOLD:
  - write_out = 0 and data_out is held (hold cycle).
  - If index = NIBBLES-1, the next state is DONE; otherwise index increments and the next state is SETUP.
- DONE (one cycle): store_out = 0, busy = 0, done = 1, data_out keeps its last nibble. Next state is IDLE unless start = 1.
- Timing, with start sampled at edge T:
  - busy and store_out are high from T+1 through T+1+3*NIBBLES.
  - write_out[i] is high only in cycle T+3+3i.
  - done is high in cycle T+2+3*NIBBLES.
- Invariants:
  - data_out never changes in a cycle where any write_out bit is high, or in the cycle immediately after.
  - At most one write_out bit is high at any time.
  - store_out is high whenever any write_out bit is high.
- start while busy (FREEZE..HOLD): ignored. The captured value is not disturbed.
- abort = 1 in any busy state: the next state is IDLE, and write_out and store_out go 0 on that edge. No done pulse. Stages already written keep their new values.
- abort with start in the same cycle while idle: abort wins and the load is not accepted.
- Reset mid-load: all outputs drop asynchronously, with no done pulse.

Test Plan:
- Normal load, NIBBLES=4, start at T with value=16'hA5C3, dir_in=1:
  - write_out=0001 with data_out=3 at T+3.
  - write_out=0010 with data_out=C at T+6.
  - write_out=0100 with data_out=5 at T+9.
  - write_out=1000 with data_out=A at T+12.
  - store_out and busy high T+1..T+13; done at T+14; updown_out=1 throughout.
- Data stability: for the load above, data_out is constant across each SETUP/STROBE/HOLD triple; a checker flags any change while write_out≠0 or in the cycle after.
- Ignored start: start at T+5 with value=16'h1111 -> the strobed nibbles are still 3, C, 5, A; done at T+14 only.
- Back-to-back: start=1 with value=16'h0F0F in the done cycle T+14 -> FREEZE at T+15, write_out=0001 with data_out=F at T+17, done at T+28.
- Abort: abort at T+7 -> write_out=0 and store_out=0 from T+8; no done; busy=0 at T+8; only write_out[0] and write_out[1] were ever strobed.
- Reset mid-load: reset asserted at T+10 -> all outputs 0 immediately and updown_out=1; after release, a new start with value=16'h0001 and dir_in=0 completes with done at +14 and updown_out=0.
